// File: rtl/msftdvip_data_resp_pkg.sv
// Shared types and constants for the CHERIoT data-port responder.
// Optional feature macro: MSFTDVIP_DATA_RESP_STALL_EN (random gnt stalls).
package msftdvip_data_resp_pkg;

  // Bit index of the capability tag inside a 33-bit word.
  localparam int TagBit = 32;

  // Widest word the response path ever carries (data + tag).
  localparam int MaxDataWidth = 33;

  // Fibonacci LFSR taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // One in-flight response; rdata is always 33 bits, upper bit unused for 32-bit builds.
  typedef struct packed {
    logic                    valid;
    logic                    err;
    logic [MaxDataWidth-1:0] rdata;
  } resp_entry_t;

  // Next LFSR state: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LfsrTaps)};
  endfunction

endpackage

// File: rtl/msftdvip_data_resp_pipe.sv
// Fixed-latency in-order response delay line: RespLatency register stages.
// Optional feature macro: none used in this file.
module msftdvip_data_resp_pipe
  import msftdvip_data_resp_pkg::*;
#(
  parameter int RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_entry_t in_i,
  output resp_entry_t out_o
);

  resp_entry_t [RespLatency-1:0] r_stage;

  // Shift every entry one stage per cycle; reset discards anything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= in_i;
      for (int i = 1; i < RespLatency; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign out_o = r_stage[RespLatency-1];

endmodule

// File: rtl/msftdvip_cheri_data_resp.sv
// Word-addressed RAM responder for the CHERIoT core data port (req/gnt/rvalid).
// Handles tagged 33-bit words, tag-clearing writes, range and malformed-cap errors.
// Optional feature macro: MSFTDVIP_DATA_RESP_STALL_EN adds LFSR-driven gnt stalls.
//
// Handshake: a request is accepted in any cycle where data_req_i and data_gnt_o
// are both high; data_gnt_o is combinational and never high without data_req_i.
// Exactly one data_rvalid_o pulse follows each accept, RespLatency cycles later,
// in acceptance order, with data_rdata_o/data_err_o valid only in that cycle.
module msftdvip_cheri_data_resp
  import msftdvip_data_resp_pkg::*;
#(
  parameter int          DataWidth      = 33,
  parameter logic [31:0] BaseAddr       = 32'h2004_0000,
  parameter int          MemDepth       = 4096,
  parameter int          RespLatency    = 1,
  parameter int          MaxOutstanding = 2,
  parameter logic [15:0] StallSeed      = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic                 data_is_cap_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic [6:0]           data_rdata_intg_o,
  output logic                 data_err_o,
  output logic [15:0]          err_cnt_o
);

  localparam int          AddrBits  = $clog2(MemDepth);
  localparam logic [32:0] MemBytes  = 33'(MemDepth) << 2;
  localparam logic [32:0] LimitAddr = {1'b0, BaseAddr} + MemBytes;

  logic                    w_stall;
  logic [2:0]              r_outstanding;
  logic [2:0]              w_out_eff;
  logic                    w_accept;
  logic                    w_in_range;
  logic                    w_malformed;
  logic                    w_err;
  logic                    w_wr_ok;
  logic [AddrBits-1:0]     w_idx;
  logic [MaxDataWidth-1:0] w_wdata;
  logic                    w_tag_rd;
  resp_entry_t             w_entry;
  resp_entry_t             w_resp;
  logic [31:0]             r_mem [MemDepth];
  logic [15:0]             r_err_cnt;

`ifdef MSFTDVIP_DATA_RESP_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running LFSR; its low two bits pick roughly one stall cycle in four.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= StallSeed;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // A retiring response frees its slot in the same cycle, so gnt can re-rise immediately.
  assign w_out_eff  = r_outstanding - {2'b00, data_rvalid_o};
  assign data_gnt_o = data_req_i & (w_out_eff < 3'(MaxOutstanding)) & ~w_stall;
  assign w_accept   = data_gnt_o;

  // Decode with a 33-bit compare so ranges touching 2^32 cannot wrap.
  assign w_in_range  = ({1'b0, data_addr_i} >= {1'b0, BaseAddr}) &&
                       ({1'b0, data_addr_i} <  LimitAddr);
  assign w_idx       = AddrBits'((data_addr_i - BaseAddr) >> 2);
  assign w_malformed = data_is_cap_i & ((data_addr_i[1:0] != 2'b00) | (data_be_i != 4'hF));
  assign w_err       = ~w_in_range | w_malformed;
  assign w_wr_ok     = w_accept & data_we_i & ~w_err;
  assign w_wdata     = MaxDataWidth'(data_wdata_i);

  // Byte-merged data write in the accept cycle; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  generate
    if (DataWidth > TagBit) begin : g_tags
      logic [MemDepth-1:0] r_tag;

      // Cap writes load the tag, plain writes with any byte enabled clear it.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_tag <= '0;
        end else if (w_wr_ok) begin
          if (data_is_cap_i) begin
            r_tag[w_idx] <= w_wdata[TagBit];
          end else if (|data_be_i) begin
            r_tag[w_idx] <= 1'b0;
          end
        end
      end

      assign w_tag_rd = r_tag[w_idx];
    end else begin : g_no_tags
      assign w_tag_rd = 1'b0;
    end
  endgenerate

  // Build the response for this cycle's accept; reads sample memory now.
  always_comb begin
    w_entry       = '0;
    w_entry.valid = w_accept;
    w_entry.err   = w_accept & w_err;
    if (w_accept && !w_err && !data_we_i) begin
      w_entry.rdata[31:0]   = r_mem[w_idx];
      w_entry.rdata[TagBit] = w_tag_rd & data_is_cap_i;
    end
  end

  msftdvip_data_resp_pipe #(
    .RespLatency (RespLatency)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (w_entry),
    .out_o (w_resp)
  );

  // Track accepted-but-unanswered requests; simultaneous accept and retire cancel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, data_rvalid_o})
        2'b10:   r_outstanding <= r_outstanding + 3'd1;
        2'b01:   r_outstanding <= r_outstanding - 3'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Count error responses as they are delivered, holding at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (w_resp.valid && w_resp.err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign data_rvalid_o     = w_resp.valid;
  assign data_err_o        = w_resp.err;
  assign data_rdata_o      = w_resp.rdata[DataWidth-1:0];
  assign data_rdata_intg_o = 7'h0;
  assign err_cnt_o         = r_err_cnt;

endmodule
